// File: rtl/exc_check_requester_if.sv
// Handshake bundle between the requester and the exception checker.
// The requester presents one operand at a time on Data/Data_valid; the checker
// answers with a one-cycle ACK carrying its 3-bit code on Exc.
interface exc_check_requester_if;
    logic [31:0] Data;
    logic        Data_valid;
    logic [2:0]  Exc;
    logic        ACK;

    modport master (output Data, output Data_valid, input Exc, input ACK);
    modport slave  (input Data, input Data_valid, output Exc, output ACK);
endinterface

// File: rtl/exc_check_requester.sv
// Initiator side of the exception-checker handshake. Accepts an (A, B) operand
// pair, sends A then B to the checker, captures both codes and returns them
// with a one-cycle Res_valid pulse. Each operand has a timeout guard; a timed
// out operand reports code 111.
// Optional build macro: SPECIAL_RESULT_EN (adds the NaN/infinity special result).
//
// state | meaning
// IDLE  | ready for a new operand pair
// REQ_A | operand A presented, waiting for ACK or timeout
// GAP   | between operands, waiting for the checker to drop ACK
// REQ_B | operand B presented, waiting for ACK or timeout
// DONE  | one-cycle result pulse
module exc_check_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 15,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [31:0]                  Op_A,
    input  logic [31:0]                  Op_B,
    input  logic                         Op_valid,
    output logic                         Op_ready,
    exc_check_requester_if.master        chk,
    output logic [2:0]                   Exc_A,
    output logic [2:0]                   Exc_B,
    output logic                         Res_valid,
    output logic                         Timeout,
    output logic [31:0]                  Special_result,
    output logic                         Special_valid
);

    typedef enum logic [2:0] {IDLE, REQ_A, GAP, REQ_B, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic [31:0]      op_b_q;
    logic             tmo_q;
    logic             timeout_hit;
    logic             load_a, load_b, capture, expire, count_en;
    logic [2:0]       code;

    // Saturating increment; the count never wraps back to zero.
    assign cnt_inc     = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign timeout_hit = (32'(cnt_inc) >= TIMEOUT_CYCLES);
    assign code        = capture ? chk.Exc : 3'b111;
    assign Timeout     = (state_q == DONE) & tmo_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state and per-cycle control decode.
    always_comb begin
        state_d   = state_q;
        Op_ready  = 1'b0;
        Res_valid = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        capture   = 1'b0;
        expire    = 1'b0;
        count_en  = 1'b0;
        case (state_q)
            IDLE: begin
                Op_ready = 1'b1;
                if (Op_valid) begin
                    load_a  = 1'b1;
                    state_d = REQ_A;
                end
            end
            REQ_A, REQ_B: begin
                if (chk.ACK) begin
                    capture = 1'b1;
                    state_d = (state_q == REQ_A) ? GAP : DONE;
                end else if (timeout_hit) begin
                    expire  = 1'b1;
                    state_d = (state_q == REQ_A) ? GAP : DONE;
                end else begin
                    count_en = 1'b1;
                end
            end
            GAP: begin
                // Hold off B until the checker has released ACK.
                if (!chk.ACK) begin
                    load_b  = 1'b1;
                    state_d = REQ_B;
                end
            end
            DONE: begin
                Res_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SPECIAL_RESULT_EN
    logic sign_a_q;

    // Sign of A must be kept because Data is overwritten with B.
    always_ff @(posedge CLK) begin
        if (RST)         sign_a_q <= 1'b0;
        else if (load_a) sign_a_q <= Op_A[31];
    end

    // Special result from the captured codes, presented only in DONE.
    always_comb begin
        Special_valid  = 1'b0;
        Special_result = 32'h0;
        if (state_q == DONE) begin
            if (Exc_A == 3'b100 || Exc_B == 3'b100) begin
                Special_valid  = 1'b1;
                Special_result = 32'h7FC0_0000;
            end else if (Exc_A == 3'b011 && Exc_B == 3'b011) begin
                Special_valid  = 1'b1;
                Special_result = (sign_a_q != op_b_q[31]) ? 32'h7FC0_0000
                                                          : {sign_a_q, 31'h7F80_0000};
            end else if (Exc_A == 3'b011) begin
                Special_valid  = 1'b1;
                Special_result = {sign_a_q, 31'h7F80_0000};
            end else if (Exc_B == 3'b011) begin
                Special_valid  = 1'b1;
                Special_result = {op_b_q[31], 31'h7F80_0000};
            end
        end
    end
`else
    assign Special_result = 32'h0;
    assign Special_valid  = 1'b0;
`endif

    // Datapath: operand staging, request line, timeout counter and code capture.
    always_ff @(posedge CLK) begin
        if (RST) begin
            op_b_q         <= 32'h0;
            chk.Data       <= 32'h0;
            chk.Data_valid <= 1'b0;
            cnt_q          <= '0;
            tmo_q          <= 1'b0;
            Exc_A          <= 3'b000;
            Exc_B          <= 3'b000;
        end else begin
            if (load_a) begin
                op_b_q         <= Op_B;
                chk.Data       <= Op_A;
                chk.Data_valid <= 1'b1;
                cnt_q          <= '0;
                tmo_q          <= 1'b0;
            end
            if (load_b) begin
                chk.Data       <= op_b_q;
                chk.Data_valid <= 1'b1;
                cnt_q          <= '0;
            end
            if (count_en) cnt_q <= cnt_inc;
            if (capture || expire) begin
                chk.Data_valid <= 1'b0;
                if (state_q == REQ_A) Exc_A <= code;
                else                  Exc_B <= code;
                if (expire) tmo_q <= 1'b1;
            end
            if (state_q == DONE) tmo_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exc_check_requester.sv
// Bench for exc_check_requester: a cycle-stepped checker responder plus a
// transaction-level model predicting codes, issue/result timing and the
// special result from the per-operand checker behaviour.
module tb_exc_check_requester;

    localparam int TMO = 15;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] Op_A, Op_B;
    logic        Op_valid;
    logic        Op_ready;
    logic [2:0]  Exc_A, Exc_B;
    logic        Res_valid;
    logic        Timeout;
    logic [31:0] Special_result;
    logic        Special_valid;

    int errors = 0;
    int checks = 0;

    exc_check_requester_if chk ();

    exc_check_requester #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Op_A           (Op_A),
        .Op_B           (Op_B),
        .Op_valid       (Op_valid),
        .Op_ready       (Op_ready),
        .chk            (chk),
        .Exc_A          (Exc_A),
        .Exc_B          (Exc_B),
        .Res_valid      (Res_valid),
        .Timeout        (Timeout),
        .Special_result (Special_result),
        .Special_valid  (Special_valid)
    );

    always #5 CLK = ~CLK;

    // {valid, result} from the final codes and operand signs.
    function automatic logic [32:0] special_model(input logic [2:0] ca, input logic [2:0] cb,
                                                  input logic sa, input logic sb);
`ifdef SPECIAL_RESULT_EN
        if (ca == 3'b100 || cb == 3'b100) return {1'b1, 32'h7FC00000};
        if (ca == 3'b011 && cb == 3'b011)
            return (sa != sb) ? {1'b1, 32'h7FC00000} : {1'b1, sa, 31'h7F800000};
        if (ca == 3'b011) return {1'b1, sa, 31'h7F800000};
        if (cb == 3'b011) return {1'b1, sb, 31'h7F800000};
        return 33'd0;
`else
        return {32'd0, (ca == 3'b000) & (cb == 3'b000) & sa & sb & 1'b0};
`endif
    endfunction

    // One pair. d* < 0 means the checker never answers that operand.
    // d = cycles after first seeing Data_valid before raising ACK, h = ACK length.
    task automatic run_pair(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int da, input int ha, input logic [2:0] ea,
                            input int db, input int hb, input logic [2:0] eb);
        int ta, eb_exp, tb_exp, k, seen, ackleft, opi, res_k, b_k, d, ready_bad;
        logic [2:0]  xa, xb, got_a, got_b;
        logic        tmo_exp, got_t, got_sv;
        logic [31:0] got_sr, got_da, got_db;
        logic [32:0] sp;

        ta     = (da < 0) ? TMO : da + 1;
        eb_exp = (da < 0) ? ta + 1 : ((ta + 1 > da + ha + 1) ? ta + 1 : da + ha + 1);
        tb_exp = (db < 0) ? eb_exp + TMO : eb_exp + db + 1;
        xa      = (da < 0) ? 3'b111 : ea;
        xb      = (db < 0) ? 3'b111 : eb;
        tmo_exp = (da < 0) || (db < 0);
        sp      = special_model(xa, xb, a[31], b[31]);

        got_a = 'x; got_b = 'x; got_t = 'x; got_sv = 'x; got_sr = 'x; got_da = 'x; got_db = 'x;
        Op_A = a; Op_B = b; Op_valid = 1'b1;
        @(posedge CLK); #1;
        Op_valid = 1'b0; Op_A = $urandom; Op_B = $urandom;
        k = 0; seen = 0; ackleft = 0; opi = 0; res_k = -1; b_k = -1; ready_bad = 0;
        while (res_k < 0 && k < 300) begin
            if (Op_ready) ready_bad++;
            if (Res_valid) begin
                res_k = k; got_a = Exc_A; got_b = Exc_B; got_t = Timeout;
                got_sv = Special_valid; got_sr = Special_result;
            end
            if (chk.Data_valid && seen == 0 && ackleft == 0) begin
                if (opi == 0) got_da = chk.Data;
                else if (opi == 1) begin got_db = chk.Data; b_k = k; end
            end
            if (ackleft > 0) begin
                ackleft--;
                if (ackleft == 0) begin chk.ACK = 1'b0; opi++; seen = 0; end
            end else if (opi < 2) begin
                if (chk.Data_valid) begin
                    seen++;
                    d = (opi == 0) ? da : db;
                    if (d >= 0 && seen == d + 1) begin
                        chk.ACK = 1'b1;
                        chk.Exc = (opi == 0) ? ea : eb;
                        ackleft = (opi == 0) ? ha : hb;
                    end
                end else if (seen > 0) begin
                    opi++; seen = 0;
                end
            end
            if (!chk.ACK) chk.Exc = 3'($urandom);
            if (res_k < 0) begin
                @(posedge CLK); #1;
                k++;
            end
        end
        chk.ACK = 1'b0;

        checks++;
        if (res_k !== tb_exp) begin
            errors++;
            $display("FAIL %s res_latency: got %0d expected %0d", name, res_k, tb_exp);
        end
        checks++;
        if (got_da !== a) begin
            errors++; $display("FAIL %s data_a: got %h expected %h", name, got_da, a);
        end
        checks++;
        if (got_db !== b || b_k !== eb_exp) begin
            errors++;
            $display("FAIL %s data_b: got %h at %0d expected %h at %0d", name, got_db, b_k, b, eb_exp);
        end
        checks++;
        if (got_a !== xa || got_b !== xb) begin
            errors++;
            $display("FAIL %s codes: got %b/%b expected %b/%b", name, got_a, got_b, xa, xb);
        end
        checks++;
        if (got_t !== tmo_exp) begin
            errors++; $display("FAIL %s timeout: got %b expected %b", name, got_t, tmo_exp);
        end
        checks++;
        if (got_sv !== sp[32] || got_sr !== sp[31:0]) begin
            errors++;
            $display("FAIL %s special: got %b/%h expected %b/%h", name, got_sv, got_sr, sp[32], sp[31:0]);
        end
        checks++;
        if (ready_bad != 0) begin
            errors++; $display("FAIL %s op_ready_busy: got %0d high cycles expected 0", name, ready_bad);
        end
        @(posedge CLK); #1;
        checks++;
        if (Res_valid !== 1'b0 || Op_ready !== 1'b1 || Exc_A !== xa || Exc_B !== xb) begin
            errors++;
            $display("FAIL %s after_done: got res=%b rdy=%b codes=%b/%b expected 0 1 %b/%b",
                     name, Res_valid, Op_ready, Exc_A, Exc_B, xa, xb);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; Op_valid = 1'b1; Op_A = $urandom; Op_B = $urandom;
        chk.ACK = 1'b1; chk.Exc = 3'b100;
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if (chk.Data !== 32'h0 || chk.Data_valid !== 1'b0 || Res_valid !== 1'b0 || Timeout !== 1'b0 ||
            Exc_A !== 3'b000 || Exc_B !== 3'b000 || Special_valid !== 1'b0 ||
            Special_result !== 32'h0 || Op_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got data=%h dv=%b res=%b tmo=%b codes=%b/%b sv=%b sr=%h rdy=%b expected all zero, rdy=1",
                     chk.Data, chk.Data_valid, Res_valid, Timeout, Exc_A, Exc_B,
                     Special_valid, Special_result, Op_ready);
        end
        Op_valid = 1'b0; chk.ACK = 1'b0;
        RST = 1'b0;
        @(posedge CLK); #1;
    endtask

    task automatic test_normal();
        run_pair("normal", 32'h3F800000, 32'h40000000, 1, 1, 3'b000, 1, 1, 3'b000);
    endtask

    task automatic test_nan_inf();
        run_pair("nan_inf", 32'h7FC00000, 32'h7F800000, 1, 1, 3'b100, 1, 1, 3'b011);
        run_pair("inf_opp", 32'h7F800000, 32'hFF800000, 0, 1, 3'b011, 2, 1, 3'b011);
        run_pair("inf_same", 32'hFF800000, 32'hFF800000, 1, 1, 3'b011, 1, 1, 3'b011);
        run_pair("inf_b_only", 32'h12345678, 32'hFF800000, 1, 1, 3'b000, 0, 1, 3'b011);
        run_pair("odd_code", 32'h00000001, 32'h80000001, 1, 1, 3'b101, 1, 1, 3'b010);
    endtask

    task automatic test_timeout();
        run_pair("timeout_a", 32'h3F800000, 32'h40400000, -1, 1, 3'b000, 1, 1, 3'b000);
        run_pair("timeout_b", 32'h40800000, 32'h7F800000, 1, 1, 3'b000, -1, 1, 3'b011);
        // ACK on the very last permitted cycle still counts as a response.
        run_pair("ack_at_limit", 32'h3F000000, 32'h3E000000, TMO - 1, 1, 3'b011, 0, 1, 3'b000);
    endtask

    task automatic test_ack_stretch();
        run_pair("ack_stretch", 32'h3F800000, 32'h40000000, 1, 3, 3'b000, 1, 1, 3'b000);
        run_pair("ack_stretch_b", 32'h3F800000, 32'h40000000, 0, 2, 3'b011, 2, 4, 3'b100);
    endtask

    task automatic test_reset_mid();
        int res_seen;
        Op_A = 32'h11111111; Op_B = 32'h22222222; Op_valid = 1'b1;
        @(posedge CLK); #1;
        Op_valid = 1'b0;
        @(posedge CLK); #1;
        chk.ACK = 1'b1; chk.Exc = 3'b100;
        @(posedge CLK); #1;
        chk.ACK = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (chk.Data_valid !== 1'b1 || chk.Data !== 32'h22222222 || Exc_A !== 3'b100) begin
            errors++;
            $display("FAIL mid_req_b: got dv=%b data=%h exc_a=%b expected 1 22222222 100",
                     chk.Data_valid, chk.Data, Exc_A);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        checks++;
        if (chk.Data_valid !== 1'b0 || Op_ready !== 1'b1 || Res_valid !== 1'b0 || Exc_A !== 3'b000) begin
            errors++;
            $display("FAIL mid_reset: got dv=%b rdy=%b res=%b exc_a=%b expected 0 1 0 000",
                     chk.Data_valid, Op_ready, Res_valid, Exc_A);
        end
        res_seen = 0;
        for (int i = 0; i < 10; i++) begin
            chk.ACK = 1'($urandom); chk.Exc = 3'($urandom);
            if (Res_valid) res_seen++;
            @(posedge CLK); #1;
        end
        chk.ACK = 1'b0;
        checks++;
        if (res_seen != 0) begin
            errors++; $display("FAIL mid_reset_no_res: got %0d pulses expected 0", res_seen);
        end
        run_pair("after_reset", 32'h3F800000, 32'h40000000, 1, 1, 3'b000, 1, 1, 3'b000);
    endtask

    task automatic test_random();
        logic [2:0] codes [5];
        logic [2:0] ca, cb;
        int da, db;
        for (int n = 0; n < 20; n++) begin
            codes[0] = 3'b000; codes[1] = 3'b011; codes[2] = 3'b100;
            codes[3] = 3'($urandom); codes[4] = 3'($urandom);
            ca = codes[$urandom_range(4, 0)];
            cb = codes[$urandom_range(4, 0)];
            da = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
            db = ($urandom_range(7, 0) == 0) ? -1 : int'($urandom_range(3, 0));
            run_pair("random", $urandom, $urandom, da, int'($urandom_range(3, 1)), ca,
                     db, int'($urandom_range(3, 1)), cb);
        end
    endtask

    initial begin
        RST = 1'b1; Op_valid = 1'b0; Op_A = 32'h0; Op_B = 32'h0;
        chk.ACK = 1'b0; chk.Exc = 3'b000;
        test_reset();
        test_normal();
        test_nan_inf();
        test_timeout();
        test_ack_stretch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_check_requester.md
Name: exc_check_requester

Overview:
- Initiator side of the exception-checker handshake (Data/Data_valid out, Exc/ACK in).
- Accepts an FPU operand pair (A, B), issues each operand in turn to the single exception checker, and captures each 3-bit exception code.
- Returns a combined result to the FPU front end, with a per-request timeout guard.
- Sits between the FPU operand-staging logic and the exception checker.

Parameters:
- TIMEOUT_CYCLES, 15, max cycles to wait for ACK per operand before abandoning it (1..255).
- CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- Op_A  input  32  IEEE-754 single operand A.
- Op_B  input  32  IEEE-754 single operand B.
- Op_valid  input  1  operand pair valid.
- Op_ready  output  1  high in IDLE; pair accepted when Op_valid & Op_ready.
- Data  output  32  operand presented to the checker.
- Data_valid  output  1  request to the checker.
- Exc  input  3  checker code: 000 normal, 011 infinity, 100 NaN.
- ACK  input  1  one-cycle checker acknowledge.
- Exc_A  output  3  captured code for A.
- Exc_B  output  3  captured code for B.
- Res_valid  output  1  one-cycle pulse; Exc_A/Exc_B/Timeout valid.
- Timeout  output  1  sticky per result: either operand timed out.
- Special_result  output  32  see Optional Feature.
- Special_valid  output  1  see Optional Feature.

Behaviour:
- Reset (RST high at a CLK edge, regardless of state):
  - State to IDLE; counter cleared.
  - Data = 0; Data_valid, Res_valid, Timeout, Special_valid = 0.
  - Exc_A = Exc_B = 000; Special_result = 0.
  - Reset mid-transaction abandons the transaction; no Res_valid is emitted.
- States: IDLE, REQ_A, GAP, REQ_B, DONE.
- IDLE:
  - Op_ready = 1.
  - On Op_valid, register Op_A and Op_B, load Data = Op_A, assert Data_valid, clear the counter, go to REQ_A.
- REQ_A:
  - Data_valid held high; Data stable.
  - On an edge with ACK = 1: capture Exc into Exc_A, drop Data_valid, go to GAP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES with no ACK: Exc_A = 111, set the internal timeout flag, drop Data_valid, go to GAP.
- GAP:
  - Data_valid low. Stay while ACK = 1; the checker must return to its compute state before the next request.
  - When ACK = 0: Data = B, assert Data_valid, clear the counter, go to REQ_B.
  - The minimum GAP dwell is 1 cycle.
- REQ_B: identical to REQ_A but captures Exc_B, then goes to DONE.
- DONE:
  - Res_valid = 1 for exactly one cycle; Timeout = internal flag.
  - Next cycle go to IDLE and clear the flag. Exc_A/Exc_B hold until the next capture.
- Latency with a checker that ACKs 1 cycle after Data_valid:
  - acceptance to Res_valid = 5 cycles.
  - Op_ready is low from the cycle after acceptance until the return to IDLE.
- Ordering and timing rules:
  - An ACK in the same cycle as the Data_valid assertion edge is not a response; sampling starts the cycle after entry to REQ_x.
  - ACK seen in IDLE or DONE is ignored.
  - Exc is sampled only on the ACK edge; Exc values in other cycles are don't-care.
  - Any Exc value other than 000/011/100 is passed through unmodified.
  - The counter saturates; it never wraps.

Optional Feature:
- Macro: SPECIAL_RESULT_EN.
- Defined: Special_result/Special_valid are computed in DONE, alongside Res_valid, with this priority:
  1. Either code = 100 → 32'h7FC00000, valid.
  2. Both codes = 011 and the registered sign bits differ → 32'h7FC00000, valid.
  3. Exactly one, or both same-sign, codes = 011 → that infinity (the sign of the infinite operand, 0x7F800000 | sign<<31), valid.
  4. Any timeout, or both codes 000 → Special_valid = 0, Special_result = 0.
- Not defined: Special_result is tied to 0 and Special_valid to 0; no related logic is synthesized.

Test Plan:
- Normal pair: A = 0x3F800000, B = 0x40000000, checker ACKs 1 cycle after each request with Exc = 000 → Res_valid pulse 5 cycles after acceptance; Exc_A = Exc_B = 000; Timeout = 0; Special_valid = 0.
- NaN/infinity: A = 0x7FC00000 (Exc 100), B = 0x7F800000 (Exc 011) → Exc_A = 100, Exc_B = 011. With SPECIAL_RESULT_EN, Special_result = 0x7FC00000 and Special_valid = 1.
- Opposite infinities: A = 0x7F800000, B = 0xFF800000, both Exc 011 → with the macro, Special_result = 0x7FC00000. Same-sign case A = B = 0xFF800000 → 0xFF800000.
- Timeout: no ACK for operand A, TIMEOUT_CYCLES = 15 → Data_valid drops after 15 waiting cycles; Exc_A = 111; B is still issued; Res_valid with Timeout = 1; Special_valid = 0.
- ACK stretched: checker holds ACK high 3 cycles after A → FSM stays in GAP until ACK = 0 and only then asserts Data_valid with Data = B.
- Reset mid-operation: RST asserted while in REQ_B → next cycle Data_valid = 0, Op_ready = 1, no Res_valid. A following pair completes normally.
